clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25_000_000, meaning clk cycles per blink half-period.
REQ-002 SHALL have parameter REPEAT_DLY, default 50_000_000, meaning hold cycles before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_RATE, default 10_000_000, meaning cycles between auto-repeat increments.
REQ-004 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port mode_btn  input  1  raw asynchronous mode button, active-high.
REQ-007 SHALL have port inc_btn  input  1  raw asynchronous increment button, active-high.
REQ-008 SHALL have ports cur_h1, cur_h0, cur_m1, cur_m0  input  4 each  live BCD time from the 24-hour clock counter.
REQ-009 SHALL have ports set_h1, set_h0, set_m1, set_m0  output  4 each  BCD time being edited or loaded.
REQ-010 SHALL have port load  output  1  one-cycle pulse; clock counter takes set_* values.
REQ-011 SHALL have port run_en  output  1  clock counter count enable.
REQ-012 SHALL have port blank_hr  output  1  display driver blanks the hour digits.
REQ-013 SHALL have port blank_min  output  1  display driver blanks the minute digits.
REQ-014 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-015 Each button SHALL pass a 2-flop synchronizer and a rising-edge detector; a raw rise sampled at edge N SHALL act at edge N+3.
REQ-016 FSM states: RUN=0, SET_HR=1, SET_MIN=2; encoding 3 unused and SHALL return to RUN.
REQ-017 RUN + mode edge -> SET_HR; cur_* SHALL be captured into set_* on the same edge; run_en SHALL go 0.
REQ-018 SET_HR + mode edge -> SET_MIN; SET_MIN + mode edge -> RUN.
REQ-019 On SET_MIN -> RUN, load SHALL be 1 for exactly one cycle; run_en SHALL be 1 from the following cycle.
REQ-020 inc edge in SET_HR: hours SHALL increment in BCD 00..23; 23 wraps to 00; minutes unchanged.
REQ-021 inc edge in SET_MIN: minutes SHALL increment in BCD 00..59; 59 wraps to 00; hours unchanged, no carry.
REQ-022 inc edge in RUN SHALL be ignored.
REQ-023 Simultaneous mode and inc edges: mode SHALL win; inc discarded.
REQ-024 Blink counter SHALL reset to 0 on every state entry; its phase starts visible and toggles every BLINK_DIV cycles.
REQ-025 blank_hr SHALL equal (state==SET_HR) AND phase; blank_min SHALL equal (state==SET_MIN) AND phase; both 0 in RUN.
REQ-026 Every inc edge SHALL restart the blink counter with visible phase.
REQ-027 Outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-028 On rst low: state=RUN, run_en=1, load=0, set_*=0, blank_*=0, synchronizers, blink and repeat counters all 0.
REQ-029 Reset asserted mid-SET SHALL discard edits; no load pulse SHALL occur on reset or its release.

Configuration
REQ-030 With CLOCK_SET_AUTO_REPEAT_EN defined: synchronized inc held high in a SET state for REPEAT_DLY cycles after its edge SHALL produce one increment, then one every REPEAT_RATE cycles until release or state change.
REQ-031 Without CLOCK_SET_AUTO_REPEAT_EN: only inc edges increment; repeat counter and logic SHALL be absent.

Structure
REQ-032 Package clock_ctrl_pkg SHALL hold the state typedef, HR_MAX=23, MIN_MAX=59 and the BCD digit width constant.
REQ-033 Sub-module btn_sync_edge (synchronizer + rising-edge pulse) SHALL be instantiated once per button.

Verification
REQ-034 Reset low then high, cur=12:34 -> state=0, run_en=1, load=0, set_*=00:00, blank_*=0.
REQ-035 cur=12:34, mode pulse -> 3 edges later state=1, set=12:34, run_en=0, blank_hr toggles every BLINK_DIV (set small, e.g. 4) cycles.
REQ-036 SET_HR at 22, two inc pulses -> 23 then 00; minutes unchanged at 34.
REQ-037 SET_MIN at 59, one inc pulse -> 00, hours unchanged; mode pulse -> state=0, load high exactly 1 cycle with set=00:00, run_en=1 next cycle.
REQ-038 mode and inc rise on same cycle in SET_HR at 05 -> state=2, hours stay 05.
REQ-039 Reset asserted during SET_MIN -> state=0, set_*=00:00, no load pulse; with CLOCK_SET_AUTO_REPEAT_EN, REPEAT_DLY=8, REPEAT_RATE=3, inc held 20 cycles -> 1 edge increment plus 5 repeat increments (edge +8, then every 3 cycles).

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock-setting controller:
// FSM state encoding, BCD digit width, and hour/minute wrap limits.
package clock_ctrl_pkg;

  localparam int DIGIT_W = 4;
  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_t;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Two-digit BCD increment that wraps to 00 once the value reaches max.
  // Out-of-range captured values also wrap rather than producing non-BCD digits.
  function automatic logic [2*DIGIT_W-1:0] bcd_inc(input digit_t tens, input digit_t ones,
                                                   input int max);
    int v;
    v = int'(tens) * 10 + int'(ones);
    if (v >= max) v = 0;
    else          v = v + 1;
    return {DIGIT_W'(v / 10), DIGIT_W'(v % 10)};
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: 2-flop synchronizer followed by a registered rising-edge pulse.
// A raw rise sampled at edge N gives pulse=1 after edge N+2, so the consumer acts at N+3.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse,
  output logic level
);

  logic s1_q, s2_q, s3_q, pulse_q;
  logic s1_d, s2_d, s3_d, pulse_d;

  always_comb begin
    s1_d    = btn;
    s2_d    = s1_q;
    s3_d    = s2_q;
    pulse_d = s2_q & ~s3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
  // s3 is aligned with the pulse, so the held level lines up with the edge.
  assign level = s3_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for a 24h BCD clock: mode button walks RUN -> SET_HR -> SET_MIN,
// inc button edits the selected field. Optional hold-to-repeat under CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int BLINK_DIV   = 25_000_000,
  parameter int REPEAT_DLY  = 50_000_000,
  parameter int REPEAT_RATE = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic [3:0] set_h1,
  output logic [3:0] set_h0,
  output logic [3:0] set_m1,
  output logic [3:0] set_m0,
  output logic       load,
  output logic       run_en,
  output logic       blank_hr,
  output logic       blank_min,
  output logic [1:0] state
);

  localparam int BLINK_W = $clog2(BLINK_DIV + 1);

  logic mode_pls, mode_lvl, inc_pls, inc_lvl;

  btn_sync_edge u_mode_sync (
    .clk   (clk),
    .rst_n (rst),
    .btn   (mode_btn),
    .pulse (mode_pls),
    .level (mode_lvl)
  );

  btn_sync_edge u_inc_sync (
    .clk   (clk),
    .rst_n (rst),
    .btn   (inc_btn),
    .pulse (inc_pls),
    .level (inc_lvl)
  );

  state_t               state_q, state_d;
  digit_t               set_h1_q, set_h0_q, set_m1_q, set_m0_q;
  digit_t               set_h1_d, set_h0_d, set_m1_d, set_m0_d;
  logic                 load_q, load_d, run_en_q, run_en_d;
  logic                 blank_hr_q, blank_hr_d, blank_min_q, blank_min_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  logic                 in_set, inc_fire, bump;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_on_q, rpt_on_d, rpt_armed_q, rpt_armed_d, rpt_fire;
  logic             unused_lvl;

  assign unused_lvl = mode_lvl;

  // Repeat runs only while inc stays held after an edge taken in a SET state.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_on_d    = rpt_on_q;
    rpt_armed_d = rpt_armed_q;
    rpt_fire    = 1'b0;
    if (!in_set || mode_pls || !inc_lvl) begin
      rpt_cnt_d   = '0;
      rpt_on_d    = 1'b0;
      rpt_armed_d = 1'b0;
    end else if (inc_pls) begin
      rpt_cnt_d   = '0;
      rpt_on_d    = 1'b1;
      rpt_armed_d = 1'b0;
    end else if (rpt_on_q) begin
      if (!rpt_armed_q && rpt_cnt_q == RPT_W'(REPEAT_DLY - 1)) begin
        rpt_fire    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b1;
      end else if (rpt_armed_q && rpt_cnt_q == RPT_W'(REPEAT_RATE - 1)) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt_q   <= '0;
      rpt_on_q    <= 1'b0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_on_q    <= rpt_on_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end

  assign inc_fire = inc_pls | rpt_fire;
`else
  logic unused_lvl;

  assign unused_lvl = mode_lvl ^ inc_lvl;
  assign inc_fire   = inc_pls;
`endif

  assign in_set = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN);
  assign bump   = inc_fire && !mode_pls && in_set;

  always_comb begin
    state_d  = state_q;
    set_h1_d = set_h1_q;
    set_h0_d = set_h0_q;
    set_m1_d = set_m1_q;
    set_m0_d = set_m0_q;
    load_d   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mode_pls) begin
          state_d  = ST_SET_HR;
          set_h1_d = cur_h1;
          set_h0_d = cur_h0;
          set_m1_d = cur_m1;
          set_m0_d = cur_m0;
        end
      end
      ST_SET_HR: begin
        if (mode_pls)  state_d = ST_SET_MIN;
        else if (bump) {set_h1_d, set_h0_d} = bcd_inc(set_h1_q, set_h0_q, HR_MAX);
      end
      ST_SET_MIN: begin
        if (mode_pls) begin
          state_d = ST_RUN;
          load_d  = 1'b1;
        end else if (bump) begin
          {set_m1_d, set_m0_d} = bcd_inc(set_m1_q, set_m0_q, MIN_MAX);
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Blink restarts visible on any state entry or edit so the edited digits stay readable.
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (state_d != state_q || bump) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    run_en_d    = (state_d == ST_RUN) && !load_d;
    blank_hr_d  = (state_d == ST_SET_HR) && phase_d;
    blank_min_d = (state_d == ST_SET_MIN) && phase_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      set_h1_q    <= '0;
      set_h0_q    <= '0;
      set_m1_q    <= '0;
      set_m0_q    <= '0;
      load_q      <= 1'b0;
      run_en_q    <= 1'b1;
      blank_hr_q  <= 1'b0;
      blank_min_q <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_h1_q    <= set_h1_d;
      set_h0_q    <= set_h0_d;
      set_m1_q    <= set_m1_d;
      set_m0_q    <= set_m0_d;
      load_q      <= load_d;
      run_en_q    <= run_en_d;
      blank_hr_q  <= blank_hr_d;
      blank_min_q <= blank_min_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign set_h1    = set_h1_q;
  assign set_h0    = set_h0_q;
  assign set_m1    = set_m1_q;
  assign set_m0    = set_m0_q;
  assign load      = load_q;
  assign run_en    = run_en_q;
  assign blank_hr  = blank_hr_q;
  assign blank_min = blank_min_q;
  assign state     = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed button sequences with a load-event scoreboard.
// Expected load contents are queued when the final mode press is driven and popped on load.
module tb_clock_set_ctrl;

  localparam int BLINK_DIV   = 4;
  localparam int REPEAT_DLY  = 8;
  localparam int REPEAT_RATE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [3:0] cur_h1 = '0, cur_h0 = '0, cur_m1 = '0, cur_m0 = '0;
  logic [3:0] set_h1, set_h0, set_m1, set_m0;
  logic       load, run_en, blank_hr, blank_min;
  logic [1:0] state;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] load_q[$];
  logic        load_seen_prev = 1'b0;

  clock_set_ctrl #(
    .BLINK_DIV   (BLINK_DIV),
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .cur_h1    (cur_h1),
    .cur_h0    (cur_h0),
    .cur_m1    (cur_m1),
    .cur_m0    (cur_m0),
    .set_h1    (set_h1),
    .set_h0    (set_h0),
    .set_m1    (set_m1),
    .set_m0    (set_m0),
    .load      (load),
    .run_en    (run_en),
    .blank_hr  (blank_hr),
    .blank_min (blank_min),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int set_val();
    return int'({set_h1, set_h0, set_m1, set_m0});
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Raw press of 2 cycles; returns on the negedge right after the FSM acted.
  task automatic press(input logic m, input logic i);
    mode_btn = m;
    inc_btn  = i;
    cycles(2);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    cycles(2);
  endtask

  // Load monitor: every load must match a queued expectation and last one cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (load_seen_prev) begin
        chk("load_width", int'(load), 0);
        chk("run_en_after_load", int'(run_en), 1);
      end
      if (load) begin
        if (load_q.size() == 0) begin
          chk("load_unexpected", 1, 0);
        end else begin
          chk("load_set", set_val(), int'(load_q.pop_front()));
          chk("run_en_during_load", int'(run_en), 0);
        end
      end
      load_seen_prev <= load;
    end else begin
      chk("load_in_reset", int'(load), 0);
      load_seen_prev <= 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    {cur_h1, cur_h0, cur_m1, cur_m0} = 16'h1234;
    cycles(3);
    rst = 1'b1;
    cycles(2);
    chk("rst_state", int'(state), 0);
    chk("rst_run_en", int'(run_en), 1);
    chk("rst_load", int'(load), 0);
    chk("rst_set", set_val(), 16'h0000);
    chk("rst_blank", int'({blank_hr, blank_min}), 0);

    press(1'b0, 1'b1);
    chk("run_inc_ignored", set_val(), 16'h0000);
    chk("run_inc_state", int'(state), 0);

    // Enter SET_HR and watch the blink phase.
    press(1'b1, 1'b0);
    chk("sethr_state", int'(state), 1);
    chk("sethr_capture", set_val(), 16'h1234);
    chk("sethr_run_en", int'(run_en), 0);
    chk("blink_visible0", int'(blank_hr), 0);
    cycles(3);
    chk("blink_visible3", int'(blank_hr), 0);
    cycles(1);
    chk("blink_blank4", int'(blank_hr), 1);
    chk("blink_min_off", int'(blank_min), 0);
    cycles(4);
    chk("blink_visible8", int'(blank_hr), 0);

    for (int k = 0; k < 10; k++) press(1'b0, 1'b1);
    chk("hr_22", set_val(), 16'h2234);
    chk("inc_restart_blink", int'(blank_hr), 0);
    press(1'b0, 1'b1);
    chk("hr_23", set_val(), 16'h2334);
    press(1'b0, 1'b1);
    chk("hr_wrap", set_val(), 16'h0034);

    press(1'b1, 1'b0);
    chk("setmin_state", int'(state), 2);
    cycles(4);
    chk("setmin_blank", int'(blank_min), 1);
    chk("setmin_hr_vis", int'(blank_hr), 0);
    for (int k = 0; k < 25; k++) press(1'b0, 1'b1);
    chk("min_59", set_val(), 16'h0059);
    press(1'b0, 1'b1);
    chk("min_wrap", set_val(), 16'h0000);

    load_q.push_back(16'h0000);
    press(1'b1, 1'b0);
    chk("back_to_run", int'(state), 0);
    cycles(3);
    chk("load_consumed", load_q.size(), 0);
    chk("run_blank", int'({blank_hr, blank_min}), 0);

    // Simultaneous mode and inc in SET_HR: mode wins.
    {cur_h1, cur_h0, cur_m1, cur_m0} = 16'h0510;
    press(1'b1, 1'b0);
    chk("sim_pre", set_val(), 16'h0510);
    press(1'b1, 1'b1);
    chk("sim_state", int'(state), 2);
    chk("sim_hours", set_val(), 16'h0510);

    // Reset in SET_MIN discards edits without loading.
    press(1'b0, 1'b1);
    chk("pre_rst_min", set_val(), 16'h0511);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_set", set_val(), 16'h0000);
    cycles(3);
    rst = 1'b1;
    cycles(4);
    chk("post_rst_state", int'(state), 0);
    chk("post_rst_run_en", int'(run_en), 1);

    // Hold inc so the synchronized level stays high 20 cycles past its edge.
    {cur_h1, cur_h0, cur_m1, cur_m0} = 16'h0000;
    press(1'b1, 1'b0);
    inc_btn = 1'b1;
    cycles(21);
    inc_btn = 1'b0;
    cycles(8);
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    chk("hold_repeat", set_val(), 16'h0600);
`else
    chk("hold_no_repeat", set_val(), 16'h0100);
`endif
    chk("hold_state", int'(state), 1);

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
